deadlock_stall_detector: RTL and testbench

- Downstream consumer of the per-kernel deadlock signal aggregation for hls_real2xfft.
- Takes the AXIS-block, instance-idle and instance-block vectors that the kernel monitor top assembles, and decides whether the dataflow region has stopped making progress.
- Raises a sticky `block` once the stall has persisted for a programmable number of cycles.
- Records which process stalled, how long it has been stalled, and emits a one-cycle report pulse for the testbench.

---
 rtl/deadlock_stall_detector.sv | 109 ++++++++++
 tb/tb_deadlock_stall_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/deadlock_stall_detector.sv
// deadlock_stall_detector: flags a dataflow region that has stopped making progress
// and latches which instance stalled and for how long.
module deadlock_stall_detector #(
    parameter int N_AXIS      = 2,
    parameter int N_IDLE      = 7,
    parameter int N_BLK       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 16,
    localparam int ID_W       = (N_BLK > 1) ? $clog2(N_BLK) : 1
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_IDLE-1:0] inst_idle_sigs,
    input  logic [N_BLK-1:0]  inst_block_sigs,
    input  logic              block_clear,
    output logic              block,
    output logic              block_rise,
    output logic [N_BLK-1:0]  block_mask,
    output logic [ID_W-1:0]   block_inst_id,
    output logic [CNT_W-1:0]  stall_cycles
);
    typedef enum logic [1:0] {MONITOR, SUSPECT, BLOCKED} state_t;
    state_t            state_q, state_d;
    logic [N_BLK-1:0]  snap_q, snap_d, mask_q, mask_d;
    logic [15:0]       hcnt_q, hcnt_d;
    logic              block_q, block_d, rise_q, rise_d;
    logic [ID_W-1:0]   id_q, id_d, enc;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              cond;
    // Blocked-or-idle everywhere, something actually blocked, kernel not fully idle,
    // and no process waiting on the environment.
    assign cond = ~&inst_idle_sigs && &(inst_idle_sigs[N_BLK-1:0] | inst_block_sigs)
                  && |inst_block_sigs && ~|axis_block_sigs;
    always_comb begin
        enc = '0;
        for (int i = N_BLK - 1; i >= 0; i--) if (snap_q[i]) enc = ID_W'(i);
    end
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        hcnt_d  = hcnt_q;
        block_d = block_q;
        rise_d  = 1'b0;
        mask_d  = mask_q;
        id_d    = id_q;
        stall_d = stall_q;
        case (state_q)
            MONITOR: if (cond) begin
                state_d = SUSPECT;
                snap_d  = inst_block_sigs;
                hcnt_d  = 16'd1;
            end
            SUSPECT: if (!cond) begin
                state_d = MONITOR;
                hcnt_d  = '0;
            end else if (inst_block_sigs != snap_q) begin
                snap_d = inst_block_sigs;
                hcnt_d = 16'd1;
            end else if (hcnt_q == 16'(HOLD_CYCLES - 1)) begin
                state_d = BLOCKED;
                block_d = 1'b1;
                rise_d  = 1'b1;
                mask_d  = snap_q;
                id_d    = enc;
                stall_d = '0;
            end else begin
                hcnt_d = hcnt_q + 16'd1;
            end
            BLOCKED: if (block_clear) begin
                state_d = MONITOR;
                block_d = 1'b0;
                mask_d  = '0;
                id_d    = '0;
                stall_d = '0;
                hcnt_d  = '0;
            end else begin
                stall_d = stall_q + CNT_W'(~&stall_q);
            end
            default: state_d = MONITOR;
        endcase
    end
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q <= MONITOR;
            snap_q  <= '0;
            hcnt_q  <= '0;
            block_q <= 1'b0;
            rise_q  <= 1'b0;
            mask_q  <= '0;
            id_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            hcnt_q  <= hcnt_d;
            block_q <= block_d;
            rise_q  <= rise_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            stall_q <= stall_d;
        end
    end
    assign block         = block_q;
    assign block_rise    = rise_q;
    assign block_mask    = mask_q;
    assign block_inst_id = id_q;
    assign stall_cycles  = stall_q;
endmodule

// File: tb/tb_deadlock_stall_detector.sv
// tb_deadlock_stall_detector: scenario tasks push expected output vectors keyed by
// edge index; each task pops and compares them as the edges occur.
module tb_deadlock_stall_detector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  axis = '0;
    logic [6:0]  idle = '0;
    logic [3:0]  blk = '0;
    logic        clr = 1'b0;
    logic        block, block_rise;
    logic [3:0]  block_mask;
    logic [1:0]  block_inst_id;
    logic [15:0] stall_cycles;
    logic [23:0] obs;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int          e;
        logic [23:0] v;
        string       nm;
    } exp_t;
    exp_t q[$];

    deadlock_stall_detector dut (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .axis_block_sigs(axis),
        .inst_idle_sigs(idle),
        .inst_block_sigs(blk),
        .block_clear(clr),
        .block(block),
        .block_rise(block_rise),
        .block_mask(block_mask),
        .block_inst_id(block_inst_id),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    assign obs = {block, block_rise, block_mask, block_inst_id, stall_cycles};

    function automatic logic [23:0] pk(bit b, bit r, logic [3:0] m, logic [1:0] id, logic [15:0] s);
        return {b, r, m, id, s};
    endfunction

    function automatic void push(int e, logic [23:0] v, string nm);
        exp_t x;
        x.e = e;
        x.v = v;
        x.nm = nm;
        q.push_back(x);
    endfunction

    task automatic do_reset;
        rst = 1'b1; axis = '0; idle = '0; blk = '0; clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        exp_t x;
        for (int e = 0; e < 3; e++) push(e, '0, "reset_hold");
        for (int e = 3; e < 103; e++) push(e, '0, "idle_run");
        for (int k = 0; k < 103; k++) begin
            if (k < 3) begin
                rst = 1'b1; axis = 2'($urandom); idle = 7'($urandom);
                blk = 4'($urandom); clr = 1'($urandom);
            end else begin
                rst = 1'b0; axis = '0; idle = '0; blk = '0; clr = 1'b0;
            end
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL reset_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    task automatic test_basic_stall;
        exp_t x;
        do_reset();
        for (int e = 0; e < 15; e++) push(e, '0, "basic_pre");
        for (int e = 15; e <= 20; e++) push(e, pk(1, e == 15, 4'b1010, 2'd1, 16'(e - 15)), "basic_blk");
        idle = 7'b0000101; blk = 4'b1010; axis = '0;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL basic_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    task automatic test_progress;
        exp_t x;
        do_reset();
        for (int e = 0; e < 25; e++) push(e, '0, "prog_pre");
        push(25, pk(1, 1, 4'b1000, 2'd3, 16'd0), "prog_blk");
        push(26, pk(1, 0, 4'b1000, 2'd3, 16'd1), "prog_after");
        idle = 7'b0000101; blk = 4'b1010; axis = '0;
        for (int k = 0; k <= 26; k++) begin
            if (k == 10) begin idle = 7'b0000111; blk = 4'b1000; end
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL prog_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    task automatic test_axis_wait;
        exp_t x;
        do_reset();
        for (int e = 0; e < 200; e++) push(e, '0, "axis_hold");
        idle = 7'b0000101; blk = 4'b1010; axis = 2'b01;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        do_reset();
        for (int e = 0; e < 65; e++) push(e, '0, "axis_pre");
        push(65, pk(1, 1, 4'b1010, 2'd1, 16'd0), "axis_blk");
        idle = 7'b0000101; blk = 4'b1010; axis = 2'b01;
        for (int k = 0; k <= 65; k++) begin
            if (k == 50) axis = '0;
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL axis_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    task automatic test_clear;
        exp_t x;
        do_reset();
        for (int e = 0; e < 15; e++) push(e, '0, "clr_pre");
        push(15, pk(1, 1, 4'b1010, 2'd1, 16'd0), "clr_blk");
        push(16, pk(1, 0, 4'b1010, 2'd1, 16'd1), "clr_stall");
        for (int e = 17; e < 33; e++) push(e, '0, "clr_released");
        push(33, pk(1, 1, 4'b1010, 2'd1, 16'd0), "clr_reblk");
        push(34, pk(1, 0, 4'b1010, 2'd1, 16'd1), "clr_rerise");
        idle = 7'b0000101; blk = 4'b1010; axis = '0;
        for (int k = 0; k <= 34; k++) begin
            clr = (k == 5 || k == 17);
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        clr = 1'b0;
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL clr_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    task automatic test_reset_mid;
        exp_t x;
        do_reset();
        for (int e = 0; e < 24; e++) push(e, '0, "mid_pre");
        push(24, pk(1, 1, 4'b1010, 2'd1, 16'd0), "mid_blk");
        idle = 7'b0000101; blk = 4'b1010; axis = '0;
        for (int k = 0; k <= 24; k++) begin
            rst = (k == 8);
            @(posedge clk); #1;
            while (q.size() != 0 && q[0].e == k) begin
                x = q.pop_front();
                tests++;
                if (obs !== x.v) begin fails++; $display("FAIL %s e%0d: got %h expected %h", x.nm, k, obs, x.v); end
            end
        end
        rst = 1'b0;
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL mid_left: got %0d expected 0", q.size()); q.delete(); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_stall();
        test_progress();
        test_axis_wait();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
